servo_pwm_bank: RTL

//  Parametrised N-channel hobby-servo PWM generator (MG-996R class) sharing one frame counter.
//  Per-channel pulse targets arrive over a valid/ready command port and are clamped to a safe range.

---
 rtl/servo_pwm_bank_if.sv | 37 +++
 rtl/servo_pwm_bank.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/servo_pwm_bank_if.sv
// Command port of the servo PWM bank.
// Carries per-channel pulse-width requests from the motion controller
// (master) to the PWM bank (slave) with a valid/ready handshake, plus the
// one-cycle error flag returned for commands addressing a missing channel.
//   cmd_valid  master->slave  command present, payload held until accepted
//   cmd_ready  slave->master  command can be accepted this cycle
//   cmd_ch     master->slave  target channel index
//   cmd_pulse  master->slave  requested pulse width in clk cycles
//   cmd_err    slave->master  accepted command had an out-of-range channel
interface servo_pwm_bank_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 21
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [CH_W-1:0]  cmd_ch;
  logic [CNT_W-1:0] cmd_pulse;
  logic             cmd_err;

  modport master (
    output cmd_valid,
    output cmd_ch,
    output cmd_pulse,
    input  cmd_ready,
    input  cmd_err
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ch,
    input  cmd_pulse,
    output cmd_ready,
    output cmd_err
  );
endinterface

// File: rtl/servo_pwm_bank.sv
// N-channel hobby-servo PWM generator sharing one frame counter.
// Pulse targets arrive over the command interface and are clamped to
// [PULSE_MIN, PULSE_MAX]; the active width of each channel slews toward its
// target by at most STEP counts per frame (STEP=0 jumps directly).
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   cmd          command interface (slave side): valid/ready/ch/pulse/err
//   enable       per-channel output enable, sampled at the frame boundary
//   pwm_out      registered servo PWM outputs
//   settled      per channel: active width equals target
//   frame_start  one-cycle pulse on the first cycle of each frame
module servo_pwm_bank #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned CNT_W     = 21,
  parameter int unsigned PERIOD    = 2_000_000,
  parameter int unsigned PULSE_MIN = 100_000,
  parameter int unsigned PULSE_MAX = 200_000,
  parameter int unsigned PULSE_CTR = 150_000,
  parameter int unsigned STEP      = 1_000
) (
  input  logic              clk,
  input  logic              rst,
  servo_pwm_bank_if.slave   cmd,
  input  logic [NUM_CH-1:0] enable,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] settled,
  output logic              frame_start
);

  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned DIFF_W = CNT_W + 1;

  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] PMIN  = CNT_W'(PULSE_MIN);
  localparam logic [CNT_W-1:0] PMAX  = CNT_W'(PULSE_MAX);
  localparam logic [CNT_W-1:0] PCTR  = CNT_W'(PULSE_CTR);
  localparam logic [CNT_W-1:0] PSTEP = CNT_W'(STEP);

  // Frame counter and frame-level flags
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_end;
  logic             frame_start_q, frame_start_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             cmd_err_q, cmd_err_d;

  // Per-channel state
  logic [CNT_W-1:0]  tgt_q [NUM_CH];
  logic [CNT_W-1:0]  tgt_d [NUM_CH];
  logic [CNT_W-1:0]  cur_q [NUM_CH];
  logic [CNT_W-1:0]  cur_d [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;

  // Command decode
  logic             accept;
  logic             ch_ok;
  logic [CNT_W-1:0] pulse_clamped;

  // One frame-boundary slew step of cur toward tgt, at most STEP counts.
  function automatic logic [CNT_W-1:0] slew(input logic [CNT_W-1:0] cur,
                                            input logic [CNT_W-1:0] tgt);
    logic signed [DIFF_W-1:0] diff;
    logic        [CNT_W-1:0]  mag;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = diff[DIFF_W-1] ? CNT_W'(-diff) : CNT_W'(diff);
    if (STEP == 0 || mag <= PSTEP) begin
      return tgt;
    end else if (diff[DIFF_W-1]) begin
      return cur - PSTEP;
    end else begin
      return cur + PSTEP;
    end
  endfunction

  // Frame counter; ready is registered from the next count so it is low
  // exactly in the boundary cycle where targets feed the slew update.
  always_comb begin
    frame_end     = (cnt_q == LAST);
    cnt_d         = frame_end ? '0 : cnt_q + CNT_W'(1);
    frame_start_d = frame_end;
    cmd_ready_d   = (cnt_d != LAST);
  end

  // Command acceptance, channel range check and clamp
  always_comb begin
    accept    = cmd.cmd_valid & cmd_ready_q;
    ch_ok     = (32'(cmd.cmd_ch) < NUM_CH);
    cmd_err_d = accept & ~ch_ok;
    if (cmd.cmd_pulse < PMIN) begin
      pulse_clamped = PMIN;
    end else if (cmd.cmd_pulse > PMAX) begin
      pulse_clamped = PMAX;
    end else begin
      pulse_clamped = cmd.cmd_pulse;
    end
  end

  // Per-channel target capture, boundary slew/enable sampling and PWM compare
  always_comb begin
    tgt_d = tgt_q;
    cur_d = cur_q;
    en_d  = en_q;
    pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = en_q[i] & (cnt_q < cur_q[i]);
      if (accept && ch_ok && (cmd.cmd_ch == CH_W'(i))) begin
        tgt_d[i] = pulse_clamped;
      end
      if (frame_end) begin
        cur_d[i] = slew(cur_q[i], tgt_q[i]);
        en_d[i]  = enable[i];
      end
    end
  end

  // Settled flags straight from registered state
  always_comb begin
    settled = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      settled[i] = (cur_q[i] == tgt_q[i]);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
      cmd_ready_q   <= 1'b1;
      cmd_err_q     <= 1'b0;
      en_q          <= '0;
      pwm_q         <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        tgt_q[i] <= PCTR;
        cur_q[i] <= PCTR;
      end
    end else begin
      cnt_q         <= cnt_d;
      frame_start_q <= frame_start_d;
      cmd_ready_q   <= cmd_ready_d;
      cmd_err_q     <= cmd_err_d;
      en_q          <= en_d;
      pwm_q         <= pwm_d;
      tgt_q         <= tgt_d;
      cur_q         <= cur_d;
    end
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign cmd.cmd_err   = cmd_err_q;
  assign pwm_out       = pwm_q;
  assign frame_start   = frame_start_q;

endmodule
